// File: rtl/alu_division_seq.sv
// Sequential Newton-Raphson floating-point divider (a / b) with valid/ready handshakes.
// One shared multiplier is reused by the seed, iteration and final-product steps.
module alu_division_seq #(
  parameter  int EXP_W   = 8,
  parameter  int MAN_W   = 23,
  parameter  int NR_ITER = 3,
  localparam int W       = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a_operand,
  input  logic [W-1:0] b_operand,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         exception,
  output logic         div_by_zero,
  output logic         overflow,
  output logic         underflow
);
  localparam int F   = MAN_W + 6;
  localparam int VW  = F + 2;
  localparam int SH  = F - MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam logic [VW-1:0] C48 = VW'(((64'd48 << F) + 64'd8) / 64'd17);
  localparam logic [VW-1:0] C32 = VW'(((64'd32 << F) + 64'd8) / 64'd17);
  localparam logic [VW-1:0] TWO = VW'(64'd2 << F);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic signed [EW2-1:0] EMAX_S = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] BIAS_S = EW2'((1 << (EXP_W - 1)) - 1);

  if (NR_ITER < 1 || NR_ITER > 6) begin : g_bad_iter
    $error("alu_division_seq: NR_ITER must be in 1..6");
  end

  typedef enum logic [2:0] {IDLE, SEED, IT_A, IT_B, FINAL, ROUND, DONE} state_t;

  state_t             r_state;
  logic [2:0]         r_it;
  logic               r_sign, r_sticky, r_out_valid;
  logic [EXP_W-1:0]   r_ea, r_eb;
  logic [VW-1:0]      r_a, r_d, r_x, r_t, r_q;
  logic [W-1:0]       r_result;
  logic               r_exc, r_dbz, r_ovf, r_unf;

  // operand decode; subnormals collapse to zero
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_man, w_b_man;
  logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic             w_sign, w_invalid;
  logic [W-1:0]     w_inf, w_zero, w_qnan;

  assign w_a_exp   = a_operand[W-2 -: EXP_W];
  assign w_b_exp   = b_operand[W-2 -: EXP_W];
  assign w_a_man   = a_operand[MAN_W-1:0];
  assign w_b_man   = b_operand[MAN_W-1:0];
  assign w_a_zero  = (w_a_exp == '0);
  assign w_b_zero  = (w_b_exp == '0);
  assign w_a_inf   = (w_a_exp == EMAX) && (w_a_man == '0);
  assign w_b_inf   = (w_b_exp == EMAX) && (w_b_man == '0);
  assign w_a_nan   = (w_a_exp == EMAX) && (w_a_man != '0);
  assign w_b_nan   = (w_b_exp == EMAX) && (w_b_man != '0);
  assign w_sign    = a_operand[W-1] ^ b_operand[W-1];
  assign w_invalid = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);
  assign w_inf     = {w_sign, EMAX, {MAN_W{1'b0}}};
  assign w_zero    = {w_sign, {(W-1){1'b0}}};
  assign w_qnan    = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  // shared multiplier; all operands carry F fractional bits
  logic [VW-1:0]   w_opa, w_opb, w_prod_sh;
  logic [F+VW-1:0] w_prod;
  logic            w_prod_lo;

  always_comb begin
    w_opa = r_x;
    w_opb = r_d;
    case (r_state)
      SEED:    begin w_opa = C32; w_opb = r_d; end
      IT_B:    begin w_opa = r_x; w_opb = r_t; end
      FINAL:   begin w_opa = r_a; w_opb = r_x; end
      default: begin w_opa = r_x; w_opb = r_d; end
    endcase
  end

  assign w_prod    = {{F{1'b0}}, w_opa} * {{F{1'b0}}, w_opb};
  assign w_prod_sh = w_prod[F +: VW];
  assign w_prod_lo = |w_prod[F-1:0];

  // q = 2*a_m/b_m lies in (1,4): shift right once when q >= 2
  logic                  w_hi, w_lost, w_guard, w_stk, w_rnd, w_carry;
  logic [F-1:0]          w_m;
  logic [MAN_W:0]        w_fsum;
  logic signed [EW2-1:0] w_adj, w_exp;

  assign w_hi    = r_q[F+1];
  assign w_m     = w_hi ? r_q[F:1] : r_q[F-1:0];
  assign w_lost  = w_hi & r_q[0];
  assign w_guard = w_m[SH-1];
  assign w_stk   = (|w_m[SH-2:0]) | w_lost | r_sticky;
  assign w_rnd   = w_guard & (w_stk | w_m[SH]);
  assign w_fsum  = {1'b0, w_m[F-1:SH]} + (MAN_W+1)'(w_rnd);
  assign w_carry = w_fsum[MAN_W];

  always_comb begin
    w_adj = '0;
    if (!w_hi)   w_adj = w_adj - EW2'(1);
    if (w_carry) w_adj = w_adj + EW2'(1);
  end

  assign w_exp = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb}) + BIAS_S + w_adj;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_it        <= '0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_exc       <= 1'b0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_sign <= w_sign;
          r_ea   <= w_a_exp;
          r_eb   <= w_b_exp;
          r_a    <= {2'b01, w_a_man, {SH{1'b0}}};
          r_d    <= {3'b001, w_b_man, {(SH-1){1'b0}}};
          r_it   <= '0;
          r_exc  <= 1'b0;
          r_dbz  <= 1'b0;
          r_ovf  <= 1'b0;
          r_unf  <= 1'b0;
          r_state <= DONE;
          if (w_invalid) begin
            r_result <= w_qnan;
            r_exc    <= 1'b1;
          end else if (w_b_zero) begin
            r_result <= w_inf;
            r_dbz    <= !w_a_inf;
          end else if (w_a_inf) begin
            r_result <= w_inf;
          end else if (w_a_zero || w_b_inf) begin
            r_result <= w_zero;
          end else begin
            r_state <= SEED;
          end
        end
        SEED: begin
          r_x     <= C48 - w_prod_sh;
          r_state <= IT_A;
        end
        IT_A: begin
          r_t     <= TWO - w_prod_sh;
          r_state <= IT_B;
        end
        IT_B: begin
          r_x <= w_prod_sh;
          if (r_it == 3'(NR_ITER - 1)) begin
            r_state <= FINAL;
          end else begin
            r_it    <= r_it + 3'd1;
            r_state <= IT_A;
          end
        end
        FINAL: begin
          r_q      <= w_prod_sh;
          r_sticky <= w_prod_lo;
          r_state  <= ROUND;
        end
        ROUND: begin
          r_out_valid <= 1'b1;
          r_state     <= DONE;
          if (w_exp >= EMAX_S) begin
            r_result <= {r_sign, EMAX, {MAN_W{1'b0}}};
            r_ovf    <= 1'b1;
          end else if (w_exp[EW2-1] || w_exp == '0) begin
            r_result <= {r_sign, {(W-1){1'b0}}};
            r_unf    <= 1'b1;
          end else begin
            r_result <= {r_sign, w_exp[EXP_W-1:0], w_fsum[MAN_W-1:0]};
          end
        end
        DONE: begin
          // special-case results arrive here with out_valid still low
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_exc       <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign exception   = r_exc;
  assign div_by_zero = r_dbz;
  assign overflow    = r_ovf;
  assign underflow   = r_unf;
endmodule

// File: doc/alu_division_seq.md
Name: alu_division_seq

Overview:
- Sequential, parametrised IEEE-754-style floating-point divider (a / b) for the ALU.
- Successor to the combinational five-stage Newton-Raphson divider:
  - configurable format width and iteration count;
  - multi-cycle FSM that reuses one multiplier;
  - valid/ready handshakes on input and output;
  - full special-case handling and separate exception flags.
- Sits beside the multiplier and adder/subtractor units behind the ALU operand registers.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, stored mantissa width. Word width W = 1+EXP_W+MAN_W.
- NR_ITER, 3, Newton-Raphson iterations. Legal range 1..6; out-of-range values stop elaboration via $error.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset. Synchronous and active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  high only in IDLE.
- a_operand  in  W  dividend.
- b_operand  in  W  divisor.
- out_valid  out  1  result and flags valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  W  quotient.
- exception  out  1  invalid operation (NaN operand, 0/0, inf/inf).
- div_by_zero  out  1  finite nonzero / zero.
- overflow  out  1  result exponent exceeds max finite.
- underflow  out  1  result below min normal, flushed to zero.

Behaviour:
- Reset: state=IDLE; out_valid=0; result=0; all flags=0; in_ready=1 from the first cycle after reset.
- rst has priority over every other event. Reset during any state aborts the operation with no output.
- Accept: in_valid&&in_ready at an edge latches both operands and leaves IDLE.
- in_ready is a function of state only. A result handshake and a new accept never occur in the same cycle.
- Specials, decoded at accept:
  - Subnormal inputs are treated as zero.
  - NaN operand, 0/0 or inf/inf -> quiet NaN {0,all-ones,1,0...} (7fc00000 for defaults); exception=1.
  - x/0 -> signed inf; div_by_zero=1.
  - inf/finite -> signed inf.
  - 0/nonzero or finite/inf -> signed zero.
  - Path: IDLE -> DONE; out_valid rises 1 cycle after accept.
- Normal path FSM: IDLE -> SEED -> (IT_A -> IT_B) x NR_ITER -> FINAL -> ROUND -> DONE.
  - Latency from accept edge to out_valid: 3+2*NR_ITER cycles (9 at defaults). Fixed, independent of data.
- Datapath:
  - Unsigned fixed point, F=MAN_W+6 fractional bits.
  - d = {1,b_man} scaled into [0.5,1).
  - SEED: x = 48/17 - (32/17)*d.
  - IT_A: t = 2 - x*d.
  - IT_B: x = x*t.
  - FINAL: q = {1,a_man}*x.
  - ROUND: normalise by at most 1 bit, then round-to-nearest-even on the guard/sticky bits. Mantissa carry-out increments the exponent.
  - One shared multiplier, used once per cycle.
- Sign = a_sign ^ b_sign, including on zero, inf and flushed results.
- Exponent: computed in EXP_W+2 bit signed arithmetic as ea - eb + bias + normalisation adjustment.
  - Value >= all-ones -> signed inf; overflow=1.
  - Value <= 0 -> signed zero; underflow=1.
- Accuracy: at defaults, normal results are within 1 ulp of the correctly rounded quotient.
- DONE:
  - result and flags stay stable while out_valid=1 and out_ready=0.
  - out_valid&&out_ready -> IDLE next cycle; out_valid drops and flags clear.
- Flags are mutually exclusive except overflow and underflow, which are never set together. Flags are meaningful only while out_valid=1.

Test Plan:
- Reset, then a=3f800000, b=40000000 -> out_valid exactly 9 cycles after accept; result=3f000000; all flags 0; in_ready=0 throughout busy.
- a=4afa06e7, b=48493b93 -> 421f097a ±1 ulp. a=cb10c062, b=4ad1bcea -> bfb0adf0 ±1 ulp. Randomised sweep of 10k normals against a real-number model, ±1 ulp.
- Specials:
  - 40400000/00000000 -> 7f800000, div_by_zero=1.
  - 00000000/00000000 -> 7fc00000, exception=1.
  - 7f800000/7f800000 -> 7fc00000, exception=1.
  - 80000000/40000000 -> 80000000.
  - Each with out_valid 1 cycle after accept.
- Range: 7f000000/3e800000 -> 7f800000, overflow=1. 00800000/41000000 -> 00000000, underflow=1.
- Backpressure: hold out_ready=0 for 20 cycles -> result and flags stable, in_ready=0, new in_valid ignored. Release -> IDLE next cycle; the next operation completes correctly.
- Assert rst at IT_B of iteration 2 -> next cycle IDLE, out_valid=0, result=0. A fresh operation then gives a correct result. Repeat with NR_ITER=1 and 6, checking latency 5 and 15.
